// File: rtl/pipeline_sequencer.sv
// Run-control and hazard sequencer for a 5-stage pipeline: owns the PC, fetch select,
// per-stage valid bits, load-use stalls and writeback enable, with start/halt/resume/step control.
module pipeline_sequencer #(
    parameter int IMW = 4,
    parameter int RFW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [IMW-1:0] start_pc,
    input  logic           resume,
    input  logic           step,
    input  logic           halt_req,
    input  logic [RFW-1:0] id_reg1,
    input  logic [RFW-1:0] id_reg2,
    input  logic           id_uses_reg2,
    input  logic [RFW-1:0] ex_wreg,
    input  logic           ex_is_load,
    output logic [IMW-1:0] pc,
    output logic           im_cs,
    output logic           if_id_en,
    output logic           id_exe_bubble,
    output logic           valid_id,
    output logic           valid_exe,
    output logic           valid_mem,
    output logic           valid_wb,
    output logic           rf_we_e,
    output logic           busy,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3,
        ST_STEP   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [IMW-1:0] pc_q, pc_d;
    // Stage valid bits: [0]=ID, [1]=EXE, [2]=MEM, [3]=WB
    logic [3:0]     valid_q, valid_d;
    logic           fetch;
    logic           stall;
    logic           haz_reg1;
    logic           haz_reg2;

    assign fetch    = ((state_q == ST_RUN) && !halt_req) || (state_q == ST_STEP);
    assign haz_reg1 = (ex_wreg == id_reg1);
    assign haz_reg2 = id_uses_reg2 && (ex_wreg == id_reg2);
    assign stall    = valid_q[0] && valid_q[1] && ex_is_load && (ex_wreg != '0)
                      && (haz_reg1 || haz_reg2);

    // A stall holds the ID instruction in place and injects a bubble into EXE.
    assign valid_d[0] = stall ? valid_q[0] : fetch;
    assign valid_d[1] = stall ? 1'b0 : valid_q[0];

    generate
        for (genvar gi = 2; gi < 4; gi++) begin : g_valid_shift
            assign valid_d[gi] = valid_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (fetch && !stall) begin
            pc_d = pc_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_pc;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (valid_q == 4'b0000) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_pc;
                end else if (resume) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // Stay until the stepped instruction is actually accepted into ID.
                if (!stall) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign pc            = pc_q;
    assign im_cs         = fetch;
    assign if_id_en      = !stall;
    assign id_exe_bubble = stall;
    assign valid_id      = valid_q[0];
    assign valid_exe     = valid_q[1];
    assign valid_mem     = valid_q[2];
    assign valid_wb      = valid_q[3];
    assign rf_we_e       = valid_q[3];
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_STEP);
    assign state         = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: expected fetches and writebacks are queued,
// a negedge monitor pops them whenever im_cs or rf_we_e is presented.
module tb_pipeline_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, resume, step, halt_req;
    logic [3:0] start_pc;
    logic [4:0] id_reg1, id_reg2, ex_wreg;
    logic       id_uses_reg2, ex_is_load;
    logic [3:0] pc;
    logic       im_cs, if_id_en, id_exe_bubble;
    logic       valid_id, valid_exe, valid_mem, valid_wb, rf_we_e, busy;
    logic [2:0] state;

    pipeline_sequencer #(.IMW(4), .RFW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .resume(resume), .step(step), .halt_req(halt_req),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_uses_reg2(id_uses_reg2),
        .ex_wreg(ex_wreg), .ex_is_load(ex_is_load),
        .pc(pc), .im_cs(im_cs), .if_id_en(if_id_en), .id_exe_bubble(id_exe_bubble),
        .valid_id(valid_id), .valid_exe(valid_exe), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .rf_we_e(rf_we_e), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 1000000;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int k;
        int pc;
    } fexp_t;

    fexp_t fq[$];
    int    wq[$];

    // Hand-derived schedule, relative to the start cycle (k=0)
    int fk[20]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 18, 19, 27, 35, 36, 37, 38, 39, 41, 42, 43};
    int fpc[20] = '{4, 5, 6, 7, 8, 9, 9, 10, 11, 12, 13, 14, 2, 3, 4, 5, 6, 15, 0, 1};
    int wk[15]  = '{5, 6, 7, 8, 10, 11, 12, 13, 22, 23, 31, 39, 45, 46, 47};

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (k=%0d)", name, act, expv, cyc - t0);
        end else begin
            $display("[TB] ok   %s = %0d (k=%0d)", name, act, cyc - t0);
        end
    endtask

    task automatic go(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every presented fetch and writeback against the queues
    always @(negedge clk) begin
        if (im_cs === 1'b1) begin
            if (fq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL fetch_extra: got pc=%0d at k=%0d expected no fetch", pc, cyc - t0);
            end else begin
                fexp_t e;
                e = fq.pop_front();
                chk("fetch_cycle", cyc - t0, e.k);
                chk("fetch_pc", int'(pc), e.pc);
            end
        end
        if (rf_we_e === 1'b1) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL wb_extra: got rf_we_e=1 at k=%0d expected 0", cyc - t0);
            end else begin
                chk("wb_cycle", cyc - t0, wq.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; resume = 1'b0; step = 1'b0; halt_req = 1'b0;
        start_pc = 4'd0; id_reg1 = 5'd1; id_reg2 = 5'd2; id_uses_reg2 = 1'b0;
        ex_wreg = 5'd0; ex_is_load = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_valids", int'({valid_id, valid_exe, valid_mem, valid_wb}), 0);
        chk("rst_im_cs", int'(im_cs), 0);

        // k=0: start from IDLE at pc 4
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < 20; i++) fq.push_back('{fk[i], fpc[i]});
        for (int i = 0; i < 15; i++) wq.push_back(wk[i]);
        reset = 1'b0; start = 1'b1; start_pc = 4'd4;
        #1;
        chk("idle_state", int'(state), 0);
        chk("idle_busy", int'(busy), 0);

        go(1); start = 1'b0; #1;
        chk("run_state", int'(state), 1);
        chk("run_pc_first", int'(pc), 4);
        chk("run_busy", int'(busy), 1);
        // start in RUN must be ignored
        go(2); start = 1'b1; start_pc = 4'd0; #1;
        go(3); start = 1'b0; #1;
        chk("start_ignored_pc", int'(pc), 6);

        // Load-use hazard on reg1
        go(6); ex_is_load = 1'b1; ex_wreg = 5'd3; id_reg1 = 5'd3; #1;
        chk("stall_if_id_en", int'(if_id_en), 0);
        chk("stall_bubble", int'(id_exe_bubble), 1);
        chk("stall_pc", int'(pc), 9);
        go(7); ex_is_load = 1'b0; ex_wreg = 5'd0; id_reg1 = 5'd1; #1;
        chk("stall_pc_held", int'(pc), 9);
        chk("stall_valid_exe", int'(valid_exe), 0);
        chk("post_stall_en", int'(if_id_en), 1);
        // ex_wreg == 0 never stalls
        go(8); ex_is_load = 1'b1; ex_wreg = 5'd0; id_reg1 = 5'd0; #1;
        chk("r0_no_stall", int'(if_id_en), 1);
        chk("r0_no_bubble", int'(id_exe_bubble), 0);
        // reg2 match ignored when not used
        go(9); ex_wreg = 5'd5; id_reg1 = 5'd1; id_reg2 = 5'd5; id_uses_reg2 = 1'b0; #1;
        chk("reg2_unused_no_stall", int'(if_id_en), 1);
        chk("stall_pair_valid", int'(valid_id & valid_exe), 1);

        // Halt and drain
        go(10); ex_is_load = 1'b0; ex_wreg = 5'd0; id_reg2 = 5'd2; halt_req = 1'b1; #1;
        chk("halt_im_cs", int'(im_cs), 0);
        chk("halt_state_run", int'(state), 1);
        go(11); halt_req = 1'b0; #1;
        chk("drain_state", int'(state), 2);
        go(14); #1;
        chk("drain_last", int'(state), 2);
        go(15); #1;
        chk("halted_state", int'(state), 3);
        chk("halted_busy", int'(busy), 0);
        chk("halted_pc", int'(pc), 12);
        go(17); resume = 1'b1; #1;
        chk("resume_pc_frozen", int'(pc), 12);
        go(18); resume = 1'b0; #1;
        chk("resume_state", int'(state), 1);
        go(20); halt_req = 1'b1; #1;
        go(21); halt_req = 1'b0; #1;
        go(25); #1;
        chk("halted2_state", int'(state), 3);

        // Single step
        go(26); step = 1'b1; #1;
        go(27); step = 1'b0; #1;
        chk("step_state", int'(state), 4);
        chk("step_pc", int'(pc), 14);
        go(28); #1;
        chk("step_drain", int'(state), 2);
        chk("step_pc_inc", int'(pc), 15);
        go(33); #1;
        chk("step_halted", int'(state), 3);

        // HALTED priority: start beats resume and step
        go(34); start = 1'b1; resume = 1'b1; step = 1'b1; start_pc = 4'd2; #1;
        go(35); start = 1'b0; resume = 1'b0; step = 1'b0; #1;
        chk("prio_state", int'(state), 1);
        chk("prio_pc", int'(pc), 2);

        // Reset with a full pipeline
        go(39); #1;
        chk("full_valids", int'({valid_id, valid_exe, valid_mem, valid_wb}), 15);
        reset = 1'b1;
        go(40); reset = 1'b0; start = 1'b1; start_pc = 4'd15; #1;
        chk("midrst_state", int'(state), 0);
        chk("midrst_pc", int'(pc), 0);
        chk("midrst_valids", int'({valid_id, valid_exe, valid_mem, valid_wb}), 0);
        chk("midrst_rf_we_e", int'(rf_we_e), 0);
        chk("midrst_busy", int'(busy), 0);

        // Wrap-around 15 -> 0 -> 1
        go(41); start = 1'b0; #1;
        chk("wrap_pc15", int'(pc), 15);
        go(42); #1;
        chk("wrap_pc0", int'(pc), 0);
        go(44); halt_req = 1'b1; #1;
        go(45); halt_req = 1'b0; #1;
        go(49); #1;
        chk("final_halted", int'(state), 3);

        go(52);
        chk("fetch_queue_empty", fq.size(), 0);
        chk("wb_queue_empty", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
